mem_port_arbiter: RTL and testbench

- Arbitrates one shared main-memory port between the L1 instruction-cache refill path and the data-side memory path.
- Issues 64-bit block bursts: read-only for instruction refills; read or write for data.
- Sits between icache_l1 / data-side logic and the main memory model or controller.
- Replaces the direct icache-to-memory hookup so both requesters share one port.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit main-memory port between icache refills and data-side bursts.
// Ties are resolved round-robin, or always in favour of data when ARB_DC_PRIORITY_EN is defined.
module mem_port_arbiter #(
    parameter int BLOCK_BYTES = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        ic_req_i,
    input  logic [31:0] ic_addr_i,
    output logic        ic_rep_ready_o,
    output logic [63:0] ic_rep_word_o,
    output logic        ic_done_o,
    input  logic        dc_req_i,
    input  logic        dc_we_i,
    input  logic [31:0] dc_addr_i,
    input  logic [63:0] dc_wdata_i,
    output logic        dc_wbeat_o,
    output logic        dc_rvalid_o,
    output logic [63:0] dc_rdata_o,
    output logic        dc_done_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [63:0] mem_rdata_i
);

    localparam int BEAT_BYTES = 8;
    localparam int BEATS      = BLOCK_BYTES / BEAT_BYTES;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

    // state    | meaning
    // IDLE     | no owner; arbitrate between pending requests
    // IC_BURST | icache owns the port for a read refill burst
    // DC_BURST | data side owns the port for a read or write burst
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IC_BURST = 2'd1,
        DC_BURST = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   count_q;
    logic [31:0]        base_q;
    logic               we_q;
    logic               grant_ic;
    logic               grant_dc;
    logic               beat_ack;
    logic               last_beat;

    assign beat_ack  = (state_q != IDLE) && mem_ack_i;
    assign last_beat = beat_ack && (count_q == CNT_W'(BEATS - 1));
    assign grant_dc  = dc_req_i && !grant_ic;

`ifdef ARB_DC_PRIORITY_EN
    assign grant_ic = ic_req_i && !dc_req_i;
`else
    logic rr_dc_q;  // set: data side wins the next tie

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_dc_q <= 1'b0;
        end else if (last_beat) begin
            rr_dc_q <= (state_q == IC_BURST);
        end
    end

    assign grant_ic = ic_req_i && (!dc_req_i || !rr_dc_q);
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_ic) begin
                    state_d = IC_BURST;
                end else if (grant_dc) begin
                    state_d = DC_BURST;
                end
            end
            IC_BURST, DC_BURST: begin
                if (last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bursts always start at the block base; the offset field comes from the counter.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
            base_q  <= '0;
            we_q    <= 1'b0;
        end else if (state_q == IDLE) begin
            count_q <= '0;
            if (grant_ic) begin
                base_q <= ic_addr_i & ~32'(BLOCK_BYTES - 1);
                we_q   <= 1'b0;
            end else if (grant_dc) begin
                base_q <= dc_addr_i & ~32'(BLOCK_BYTES - 1);
                we_q   <= dc_we_i;
            end
        end else if (beat_ack) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    always_comb begin
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        ic_rep_ready_o = 1'b0;
        ic_rep_word_o  = '0;
        ic_done_o      = 1'b0;
        dc_wbeat_o     = 1'b0;
        dc_rvalid_o    = 1'b0;
        dc_rdata_o     = '0;
        dc_done_o      = 1'b0;
        case (state_q)
            IC_BURST: begin
                mem_req_o      = 1'b1;
                mem_addr_o     = base_q + (32'(count_q) << 3);
                ic_rep_ready_o = mem_ack_i;
                ic_rep_word_o  = mem_ack_i ? mem_rdata_i : 64'd0;
                ic_done_o      = last_beat;
            end
            DC_BURST: begin
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = base_q + (32'(count_q) << 3);
                mem_wdata_o = we_q ? dc_wdata_i : 64'd0;
                dc_wbeat_o  = we_q && mem_ack_i;
                dc_rvalid_o = !we_q && mem_ack_i;
                dc_rdata_o  = (!we_q && mem_ack_i) ? mem_rdata_i : 64'd0;
                dc_done_o   = last_beat;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner-case sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int BLOCK_BYTES = 64;
    localparam int BEATS       = BLOCK_BYTES / 8;
`ifdef ARB_DC_PRIORITY_EN
    localparam bit DC_PRIO = 1'b1;
`else
    localparam bit DC_PRIO = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        ic_req_i = 1'b0;
    logic [31:0] ic_addr_i = '0;
    logic        ic_rep_ready_o;
    logic [63:0] ic_rep_word_o;
    logic        ic_done_o;
    logic        dc_req_i = 1'b0;
    logic        dc_we_i = 1'b0;
    logic [31:0] dc_addr_i = '0;
    logic [63:0] dc_wdata_i = '0;
    logic        dc_wbeat_o;
    logic        dc_rvalid_o;
    logic [63:0] dc_rdata_o;
    logic        dc_done_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;

    mem_port_arbiter #(.BLOCK_BYTES(BLOCK_BYTES)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i),
        .ic_rep_ready_o(ic_rep_ready_o), .ic_rep_word_o(ic_rep_word_o), .ic_done_o(ic_done_o),
        .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
        .dc_wbeat_o(dc_wbeat_o), .dc_rvalid_o(dc_rvalid_o), .dc_rdata_o(dc_rdata_o), .dc_done_o(dc_done_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [63:0] mem_wdata;
        logic        ic_rdy;
        logic [63:0] ic_word;
        logic        ic_done;
        logic        dc_wbeat;
        logic        dc_rvalid;
        logic [63:0] dc_rdata;
        logic        dc_done;
    } obs_t;

    typedef struct {
        bit          rst;
        bit          ic_req;
        logic [31:0] ic_addr;
        bit          dc_req;
        bit          dc_we;
        logic [31:0] dc_addr;
        bit          ack;
    } in_t;

    typedef struct {
        bit          ic_req;
        bit          dc_req;
        bit          dc_we;
        bit          ack;
        bit          e_req;
        bit          e_we;
        logic [31:0] e_addr;
        bit          e_ic_rdy;
        bit          e_ic_done;
        bit          e_wbeat;
        bit          e_rvalid;
        bit          e_dc_done;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    obs_t act_o;
    obs_t exp_o;
    int   done_log[$];

    // Reference model: who owns the port, which beat is next, and who wins the next tie.
    int          m_owner;   // 0 none, 1 icache, 2 data
    int          m_beat;
    logic [31:0] m_base;
    bit          m_we;
    bit          m_fav_dc;

    function automatic void model_reset();
        m_owner  = 0;
        m_beat   = 0;
        m_base   = '0;
        m_we     = 1'b0;
        m_fav_dc = 1'b0;
    endfunction

    function automatic obs_t model_expect();
        obs_t e = '0;
        if (reset_i) return e;
        if (m_owner != 0) begin
            e.mem_req  = 1'b1;
            e.mem_we   = m_we;
            e.mem_addr = m_base + 32'(8 * m_beat);
            if (m_owner == 2 && m_we) e.mem_wdata = dc_wdata_i;
            if (mem_ack_i) begin
                if (m_owner == 1) begin
                    e.ic_rdy  = 1'b1;
                    e.ic_word = mem_rdata_i;
                    e.ic_done = (m_beat == BEATS - 1);
                end else begin
                    if (m_we) begin
                        e.dc_wbeat = 1'b1;
                    end else begin
                        e.dc_rvalid = 1'b1;
                        e.dc_rdata  = mem_rdata_i;
                    end
                    e.dc_done = (m_beat == BEATS - 1);
                end
            end
        end
        return e;
    endfunction

    function automatic void model_advance();
        int pick;
        pick = 0;
        if (reset_i) begin
            model_reset();
            return;
        end
        if (m_owner != 0) begin
            if (mem_ack_i) begin
                m_beat++;
                if (m_beat == BEATS) begin
                    m_fav_dc = (m_owner == 1);
                    m_owner  = 0;
                end
            end
        end else begin
            if (ic_req_i && dc_req_i) pick = (DC_PRIO || m_fav_dc) ? 2 : 1;
            else if (ic_req_i)        pick = 1;
            else if (dc_req_i)        pick = 2;
            if (pick == 1) begin
                m_owner = 1;
                m_base  = ic_addr_i - (ic_addr_i % 32'(BLOCK_BYTES));
                m_we    = 1'b0;
                m_beat  = 0;
            end else if (pick == 2) begin
                m_owner = 2;
                m_base  = dc_addr_i - (dc_addr_i % 32'(BLOCK_BYTES));
                m_we    = dc_we_i;
                m_beat  = 0;
            end
        end
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s.mem_req   = mem_req_o;
        s.mem_we    = mem_we_o;
        s.mem_addr  = mem_addr_o;
        s.mem_wdata = mem_wdata_o;
        s.ic_rdy    = ic_rep_ready_o;
        s.ic_word   = ic_rep_word_o;
        s.ic_done   = ic_done_o;
        s.dc_wbeat  = dc_wbeat_o;
        s.dc_rvalid = dc_rvalid_o;
        s.dc_rdata  = dc_rdata_o;
        s.dc_done   = dc_done_o;
        return s;
    endfunction

    function automatic in_t mk(bit rst, bit icr, logic [31:0] ica, bit dcr, bit dcw,
                               logic [31:0] dca, bit ack);
        in_t s;
        s.rst = rst; s.ic_req = icr; s.ic_addr = ica;
        s.dc_req = dcr; s.dc_we = dcw; s.dc_addr = dca; s.ack = ack;
        return s;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic cmp_obs(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input in_t s);
        reset_i     = s.rst;
        ic_req_i    = s.ic_req;
        ic_addr_i   = s.ic_addr;
        dc_req_i    = s.dc_req;
        dc_we_i     = s.dc_we;
        dc_addr_i   = s.dc_addr;
        mem_ack_i   = s.ack;
        dc_wdata_i  = {$urandom, $urandom};
        mem_rdata_i = {$urandom, $urandom};
    endtask

    // One clock cycle: drive after the edge, check at the falling edge, advance the model.
    task automatic step(input in_t s, input string tag);
        @(posedge clk_i);
        #1;
        drive(s);
        @(negedge clk_i);
        cyc++;
        exp_o = model_expect();
        act_o = sample();
        cmp_obs(tag, act_o, exp_o);
        if (act_o.ic_done) done_log.push_back(1);
        if (act_o.dc_done) done_log.push_back(2);
        model_advance();
    endtask

    vec_t vec[28];

    initial begin
        int          t_done;
        int          t_dc;
        int          n_ic_done;
        int          n_dc_done;
        int          got;
        int          exp_order[3];
        logic [31:0] a_ic;
        logic [31:0] a_dc;
        logic [31:0] base;
        obs_t        pre;
        bit          ic_pend;
        bit          dc_pend;
        bit          dc_w;

        // Single icache miss with ack every cycle, then a data write acked every other cycle,
        // then stray acks while idle.
        for (int i = 0; i < 28; i++) vec[i] = '{default: '0};
        vec[0].ic_req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            vec[i].ic_req    = 1'b1;
            vec[i].ack       = 1'b1;
            vec[i].e_req     = 1'b1;
            vec[i].e_addr    = 32'h1200 + 32'(8 * (i - 1));
            vec[i].e_ic_rdy  = 1'b1;
            vec[i].e_ic_done = (i == 8);
        end
        vec[9].dc_req = 1'b1;
        vec[9].dc_we  = 1'b1;
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 2; k++) begin
                vec[10 + 2*j + k].dc_req    = 1'b1;
                vec[10 + 2*j + k].dc_we     = 1'b1;
                vec[10 + 2*j + k].ack       = (k == 1);
                vec[10 + 2*j + k].e_req     = 1'b1;
                vec[10 + 2*j + k].e_we      = 1'b1;
                vec[10 + 2*j + k].e_addr    = 32'h8040 + 32'(8 * j);
                vec[10 + 2*j + k].e_wbeat   = (k == 1);
                vec[10 + 2*j + k].e_dc_done = (k == 1) && (j == 7);
            end
        end
        vec[26].ack = 1'b1;
        vec[27].ack = 1'b1;

        model_reset();
        step(mk(1, 0, 0, 0, 0, 0, 0), "reset_state");
        step(mk(1, 0, 0, 0, 0, 0, 1), "reset_state_ack");

        for (int i = 0; i < 28; i++) begin
            step(mk(0, vec[i].ic_req, 32'h0000_1234, vec[i].dc_req, vec[i].dc_we,
                    32'h0000_8040, vec[i].ack), "table_model");
            cmp("table_vec",
                64'({act_o.mem_req, act_o.mem_we, act_o.mem_addr, act_o.ic_rdy, act_o.ic_done,
                     act_o.dc_wbeat, act_o.dc_rvalid, act_o.dc_done}),
                64'({vec[i].e_req, vec[i].e_we, vec[i].e_addr, vec[i].e_ic_rdy, vec[i].e_ic_done,
                     vec[i].e_wbeat, vec[i].e_rvalid, vec[i].e_dc_done}));
        end

        // Simultaneous requests out of reset, both held.
        a_ic = 32'h0004_0010;
        a_dc = 32'h0009_00f8;
        step(mk(1, 0, 0, 0, 0, 0, 0), "simul_reset");
        done_log.delete();
        for (int i = 0; i < 28; i++) step(mk(0, 1, a_ic, 1, 0, a_dc, 1), "simul_model");
        if (DC_PRIO) exp_order = '{2, 2, 2};
        else         exp_order = '{1, 2, 1};
        for (int k = 0; k < 3; k++) begin
            got = (k < done_log.size()) ? done_log[k] : 0;
            cmp("grant_order", 64'(got), 64'(exp_order[k]));
        end

        // Icache drops its request at beat 3; pending data read follows after one idle cycle.
        step(mk(1, 0, 0, 0, 0, 0, 0), "drop_reset");
        done_log.delete();
        t_done = -1;
        t_dc   = -1;
        step(mk(0, 1, 32'h0000_2468, 0, 0, 0, 0), "drop_model");
        for (int i = 1; i <= 20; i++) begin
            step(mk(0, (i <= 3), 32'h0000_2468, 1, 0, 32'h0000_7700, 1), "drop_model");
            if (act_o.ic_done) t_done = cyc;
            if (t_done >= 0 && t_dc < 0 && cyc > t_done && act_o.mem_req) t_dc = cyc;
        end
        n_ic_done = 0;
        n_dc_done = 0;
        foreach (done_log[k]) begin
            if (done_log[k] == 1) n_ic_done++;
            else                  n_dc_done++;
        end
        cmp("drop_ic_done_count", 64'(n_ic_done), 64'd1);
        cmp("drop_dc_done_count", 64'(n_dc_done), 64'd1);
        cmp("drop_idle_gap", 64'(t_dc - t_done), 64'd2);

        // Asynchronous reset during beat 5 of a data read.
        a_dc = 32'h1357_9bdf;
        base = 32'h1357_9bc0;
        step(mk(1, 0, 0, 0, 0, 0, 0), "rst_mid_reset");
        done_log.delete();
        step(mk(0, 0, 0, 1, 0, a_dc, 0), "rst_mid_model");
        for (int i = 0; i < 5; i++) step(mk(0, 0, 0, 1, 0, a_dc, 1), "rst_mid_model");
        @(posedge clk_i);
        #1;
        drive(mk(0, 0, 0, 1, 0, a_dc, 1));
        #2;
        pre = sample();
        cmp("pre_reset_addr", 64'(pre.mem_addr), 64'(base + 32'd40));
        reset_i = 1'b1;
        #1;
        cmp_obs("async_reset_zero", sample(), '0);
        model_reset();
        step(mk(1, 0, 0, 1, 0, a_dc, 1), "rst_mid_hold");
        step(mk(0, 0, 0, 1, 0, a_dc, 0), "rst_mid_regrant");
        step(mk(0, 0, 0, 1, 0, a_dc, 1), "rst_mid_model");
        cmp("restart_base", 64'(act_o.mem_addr), 64'(base));
        for (int i = 0; i < 9; i++) step(mk(0, 0, 0, (i < 7), 0, a_dc, 1), "rst_mid_model");
        cmp("rst_mid_done_count", 64'(done_log.size()), 64'd1);

        // Randomized traffic with random memory latency and stray acks.
        step(mk(1, 0, 0, 0, 0, 0, 0), "rand_reset");
        ic_pend = 1'b0;
        dc_pend = 1'b0;
        dc_w    = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!ic_pend && ($urandom_range(3) == 0)) begin
                ic_pend = 1'b1;
                a_ic    = $urandom;
            end
            if (!dc_pend && ($urandom_range(3) == 0)) begin
                dc_pend = 1'b1;
                a_dc    = $urandom;
                dc_w    = $urandom_range(1) == 1;
            end
            step(mk(0, ic_pend, a_ic, dc_pend, dc_w, a_dc, $urandom_range(1) == 1), "random");
            if (exp_o.ic_done) ic_pend = 1'b0;
            if (exp_o.dc_done) dc_pend = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
